// File: rtl/spike_event_packer.sv
// Spike event packer: timestamps motoneuron spikes, buffers them in a FIFO
// and serializes each event as two 16-bit words (ts, id) for the host pipe.
module spike_event_packer #(
    parameter int DEPTH_LOG2 = 9,
    parameter int ID_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spike_in,
    input  logic [ID_W-1:0]       spkid_in,
    input  logic                  tick,
    input  logic                  pipe_read,
    output logic [15:0]           pipe_dout,
    output logic                  pipe_ready,
    input  logic                  clear_ovf,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    output logic [DEPTH_LOG2:0]   fill_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [15:0]         ts;
    logic [15:0]         id_ext;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_data;
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;
    logic [1:0]          state;
    logic [15:0]         id_hold;

    assign id_ext  = 16'(spkid_in);
    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0])
                && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

    // The serializer pops whenever it is about to present a new ts word.
    assign pop = !empty
              && ((state == ST_IDLE) || ((state == ST_LO) && pipe_read));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = spike_in && (!full || pop);
    assign drop = spike_in && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {ts, id_ext};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts <= 16'd0;
        end else if (tick) begin
            ts <= ts + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + PTR_ONE;
                2'b01:   fill_level <= fill_level - PTR_ONE;
                default: fill_level <= fill_level;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pipe_dout  <= 16'd0;
            pipe_ready <= 1'b0;
            id_hold    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        pipe_dout  <= rd_data[31:16];
                        id_hold    <= rd_data[15:0];
                        pipe_ready <= 1'b1;
                        state      <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (pipe_read) begin
                        pipe_dout <= id_hold;
                        state     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (pipe_read) begin
                        if (pop) begin
                            pipe_dout <= rd_data[31:16];
                            id_hold   <= rd_data[15:0];
                            state     <= ST_HI;
                        end else begin
                            pipe_ready <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    pipe_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer: vector table for the basic flow,
// hand sequences for overflow, full-FIFO push/pop, streaming and reset.
module tb_spike_event_packer;

    localparam int DL2 = 9;

    logic         clk;
    logic         reset_n;
    logic         spike_in;
    logic [15:0]  spkid_in;
    logic         tick;
    logic         pipe_read;
    logic [15:0]  pipe_dout;
    logic         pipe_ready;
    logic         clear_ovf;
    logic         overflow;
    logic [15:0]  drop_cnt;
    logic [DL2:0] fill_level;

    int errors = 0;
    int checks = 0;

    spike_event_packer #(.DEPTH_LOG2(DL2), .ID_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike_in   (spike_in),
        .spkid_in   (spkid_in),
        .tick       (tick),
        .pipe_read  (pipe_read),
        .pipe_dout  (pipe_dout),
        .pipe_ready (pipe_ready),
        .clear_ovf  (clear_ovf),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rep;
        logic        sp;
        logic [15:0] id;
        logic        tk;
        logic        rd;
        logic        rdy;
        logic        chkd;
        logic [15:0] dout;
        int          fill;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic sp, input logic [15:0] id,
                        input logic tk, input logic rd, input logic cl);
        spike_in  = sp;
        spkid_in  = id;
        tick      = tk;
        pipe_read = rd;
        clear_ovf = cl;
        @(posedge clk);
        #1;
        spike_in  = 1'b0;
        tick      = 1'b0;
        pipe_read = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(pipe_ready), 32'd0);
        chk({tag, "_dout"},  32'(pipe_dout),  32'd0);
        chk({tag, "_fill"},  32'(fill_level), 32'd0);
        chk({tag, "_ovf"},   32'(overflow),   32'd0);
        chk({tag, "_drop"},  32'(drop_cnt),   32'd0);
    endtask

    logic [15:0] stream_exp[8];

    initial begin
        //         rep sp id      tk rd  rdy chkd dout    fill
        tv[0]  = '{3,  0, 16'h0,  1, 0,  0,  1,   16'h0,  0};
        tv[1]  = '{1,  1, 16'h5,  0, 0,  0,  1,   16'h0,  1};
        tv[2]  = '{1,  0, 16'h0,  0, 0,  1,  1,   16'h3,  0};
        tv[3]  = '{1,  0, 16'h0,  0, 0,  1,  1,   16'h3,  0};
        tv[4]  = '{1,  0, 16'h0,  0, 1,  1,  1,   16'h5,  0};
        tv[5]  = '{1,  0, 16'h0,  0, 1,  0,  0,   16'h0,  0};
        tv[6]  = '{13, 0, 16'h0,  1, 0,  0,  0,   16'h0,  0};
        tv[7]  = '{1,  1, 16'hA,  1, 0,  0,  0,   16'h0,  1};
        tv[8]  = '{1,  1, 16'hB,  0, 0,  1,  1,   16'h10, 1};
        tv[9]  = '{1,  0, 16'h0,  0, 1,  1,  1,   16'hA,  1};
        tv[10] = '{1,  0, 16'h0,  0, 1,  1,  1,   16'h11, 0};
        tv[11] = '{1,  0, 16'h0,  0, 1,  1,  1,   16'hB,  0};
        tv[12] = '{1,  0, 16'h0,  0, 1,  0,  0,   16'h0,  0};
        tv[13] = '{1,  0, 16'h0,  0, 1,  0,  0,   16'h0,  0};
        tv[14] = '{1,  1, 16'hFFFF, 0, 0, 0, 0,   16'h0,  1};
        tv[15] = '{1,  0, 16'h0,  0, 0,  1,  1,   16'h11, 0};

        spike_in  = 1'b0;
        spkid_in  = 16'h0;
        tick      = 1'b0;
        pipe_read = 1'b0;
        clear_ovf = 1'b0;
        reset_n   = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < tv[i].rep; r++) begin
                step(tv[i].sp, tv[i].id, tv[i].tk, tv[i].rd, 1'b0);
            end
            chk($sformatf("vec%0d_ready", i), 32'(pipe_ready), 32'(tv[i].rdy));
            chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(tv[i].fill));
            if (tv[i].chkd) begin
                chk($sformatf("vec%0d_dout", i), 32'(pipe_dout), 32'(tv[i].dout));
            end
        end

        // Drain the 0xFFFF event: id word must come through unchanged.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("wide_id", 32'(pipe_dout), 32'h0000FFFF);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("wide_idle", 32'(pipe_ready), 32'd0);

        // 600 spikes, no reads: 512 in FIFO + 1 in serializer, 87 dropped.
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("ovf_fill", 32'(fill_level), 32'd512);
        chk("ovf_drop", 32'(drop_cnt), 32'd87);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_dout", 32'(pipe_dout), 32'h11);

        // HI -> LO, then spike with a popping read while full.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("full_id0", 32'(pipe_dout), 32'd0);
        step(1'b1, 16'h777, 1'b0, 1'b1, 1'b0);
        chk("full_pp_fill", 32'(fill_level), 32'd512);
        chk("full_pp_drop", 32'(drop_cnt), 32'd87);
        chk("full_pp_dout", 32'(pipe_dout), 32'h11);

        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        step(1'b1, 16'h9, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        step(1'b1, 16'h9, 1'b0, 1'b0, 1'b0);
        chk("drop2_cnt", 32'(drop_cnt), 32'd2);

        // Into LO with the FIFO full, then an asynchronous reset mid-cycle.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("lo_dout", 32'(pipe_dout), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_ts", 32'(pipe_dout), 32'h2);
        chk("rst_ready", 32'(pipe_ready), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("rst_id", 32'(pipe_dout), 32'h7);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Four events with ts 2..5, then a continuous read stream.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
        end
        stream_exp = '{16'h2, 16'h1, 16'h3, 16'h2,
                       16'h4, 16'h3, 16'h5, 16'h4};
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("stream%0d_ready", k), 32'(pipe_ready), 32'd1);
            chk($sformatf("stream%0d_word", k), 32'(pipe_dout),
                32'(stream_exp[k]));
            step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        end
        chk("stream_end_ready", 32'(pipe_ready), 32'd0);
        chk("stream_end_fill", 32'(fill_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
